// File: rtl/lpm_mac_multichan.sv
// lpm_mac_multichan: pipelined multi-channel multiply-accumulate.
// Time-multiplexed samples tagged with a channel id are multiplied through an
// LPM_PIPELINE-deep product pipeline. A single read-modify-write stage then
// updates the accumulator for that channel, and a dump emits the result.
//
// Handshake: in_valid qualifies a sample on any cycle with clken=1. There is no
// ready signal: the block accepts one sample per cycle and never stalls the
// source. out_valid is a one-clken-cycle pulse, also without ready. The consumer
// must take result/out_chan/overflow on the cycle that out_valid is high.
// clken=0 freezes every register, so all outputs hold.

module lpm_mac_multichan #(
  parameter int    LPM_WIDTHA         = 16,
  parameter int    LPM_WIDTHB         = 16,
  parameter int    LPM_WIDTHP         = 40,
  parameter int    LPM_CHANNELS       = 4,
  parameter int    LPM_CHW            = 2,
  parameter int    LPM_PIPELINE       = 2,
  parameter string LPM_REPRESENTATION = "SIGNED",
  parameter bit    LPM_SATURATE       = 1'b1
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic [LPM_CHW-1:0]    in_chan,
  input  logic                  in_clear,
  input  logic                  in_dump,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  output logic                  out_valid,
  output logic [LPM_CHW-1:0]    out_chan,
  output logic [LPM_WIDTHP-1:0] result,
  output logic                  overflow,
  output logic                  chan_err
);

  localparam int W  = LPM_WIDTHA + LPM_WIDTHB;
  localparam int P  = LPM_WIDTHP;
  localparam int NP = LPM_PIPELINE;
  localparam bit IS_SIGNED = (LPM_REPRESENTATION == "SIGNED");
  localparam logic [P-1:0] SAT_MAX = IS_SIGNED ? {1'b0, {(P-1){1'b1}}} : {P{1'b1}};
  localparam logic [P-1:0] SAT_MIN = {1'b1, {(P-1){1'b0}}};

  // An unknown representation is a configuration error: stop at elaboration.
  if (LPM_REPRESENTATION != "SIGNED" && LPM_REPRESENTATION != "UNSIGNED") begin : g_bad_repr
    $fatal(1, "lpm_mac_multichan: LPM_REPRESENTATION must be SIGNED or UNSIGNED");
  end

  // S0 input register
  logic                  s0_valid;
  logic                  s0_clear;
  logic                  s0_dump;
  logic [LPM_CHW-1:0]    s0_chan;
  logic [LPM_WIDTHA-1:0] s0_a;
  logic [LPM_WIDTHB-1:0] s0_b;
  logic                  chan_ok;

  assign chan_ok = (32'(in_chan) < LPM_CHANNELS);

  // Capture the sample. Out-of-range channels are dropped here and flagged.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s0_valid <= 1'b0;
      s0_clear <= 1'b0;
      s0_dump  <= 1'b0;
      s0_chan  <= '0;
      s0_a     <= '0;
      s0_b     <= '0;
      chan_err <= 1'b0;
    end else if (clken) begin
      s0_valid <= in_valid && chan_ok;
      chan_err <= in_valid && !chan_ok;
      s0_clear <= in_clear;
      s0_dump  <= in_dump;
      s0_chan  <= in_chan;
      s0_a     <= dataa;
      s0_b     <= datab;
    end
  end

  // Full-width product. Because both operands are extended to W bits, the low
  // W bits of one unsigned multiply are correct for either representation.
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] prod_s0;

  // Extend operands and form the product feeding S1
  always_comb begin
    a_ext   = IS_SIGNED ? {{LPM_WIDTHB{s0_a[LPM_WIDTHA-1]}}, s0_a} : {{LPM_WIDTHB{1'b0}}, s0_a};
    b_ext   = IS_SIGNED ? {{LPM_WIDTHA{s0_b[LPM_WIDTHB-1]}}, s0_b} : {{LPM_WIDTHA{1'b0}}, s0_b};
    prod_s0 = a_ext * b_ext;
  end

  // S1..S_NP product pipeline
  logic [NP:1]        p_valid;
  logic [NP:1]        p_clear;
  logic [NP:1]        p_dump;
  logic [LPM_CHW-1:0] p_chan [1:NP];
  logic [W-1:0]       p_prod [1:NP];

  // Shift the product and its control tag down the pipeline
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      p_valid <= '0;
      p_clear <= '0;
      p_dump  <= '0;
      for (int i = 1; i <= NP; i++) begin
        p_chan[i] <= '0;
        p_prod[i] <= '0;
      end
    end else if (clken) begin
      p_valid[1] <= s0_valid;
      p_clear[1] <= s0_clear;
      p_dump[1]  <= s0_dump;
      p_chan[1]  <= s0_chan;
      p_prod[1]  <= prod_s0;
      for (int i = 2; i <= NP; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_clear[i] <= p_clear[i-1];
        p_dump[i]  <= p_dump[i-1];
        p_chan[i]  <= p_chan[i-1];
        p_prod[i]  <= p_prod[i-1];
      end
    end
  end

  // S_ACC: per-channel accumulators and sticky overflow flags
  logic [P-1:0]            acc [LPM_CHANNELS];
  logic [LPM_CHANNELS-1:0] sticky;
  logic [LPM_CHW-1:0]      acc_chan;
  logic [W-1:0]            cur_prod;
  logic [P-1:0]            base;
  logic [P:0]              base_ext;
  logic [P:0]              prod_ext;
  logic [P:0]              sum;
  logic                    ovf;
  logic [P-1:0]            new_acc;
  logic                    new_sticky;

  // Sum at P+1 bits, detect overflow, then clamp or wrap
  always_comb begin
    acc_chan   = p_chan[NP];
    cur_prod   = p_prod[NP];
    prod_ext   = IS_SIGNED ? {{(P+1-W){cur_prod[W-1]}}, cur_prod} : {{(P+1-W){1'b0}}, cur_prod};
    base       = p_clear[NP] ? '0 : acc[acc_chan];
    base_ext   = IS_SIGNED ? {base[P-1], base} : {1'b0, base};
    sum        = base_ext + prod_ext;
    ovf        = IS_SIGNED ? (sum[P] != sum[P-1]) : sum[P];
    if (ovf && LPM_SATURATE) begin
      // In signed mode, bit P carries the true sign of the sum.
      new_acc = (IS_SIGNED && sum[P]) ? SAT_MIN : SAT_MAX;
    end else begin
      new_acc = sum[P-1:0];
    end
    new_sticky = (!p_clear[NP] && sticky[acc_chan]) || ovf;
  end

  // Read-modify-write of the channel, or emit and zero it on dump
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int c = 0; c < LPM_CHANNELS; c++) begin
        acc[c] <= '0;
      end
      sticky    <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (clken) begin
      out_valid <= p_valid[NP] && p_dump[NP];
      if (p_valid[NP]) begin
        if (p_dump[NP]) begin
          acc[acc_chan]    <= '0;
          sticky[acc_chan] <= 1'b0;
          out_chan         <= acc_chan;
          result           <= new_acc;
          overflow         <= new_sticky;
        end else begin
          acc[acc_chan]    <= new_acc;
          sticky[acc_chan] <= new_sticky;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpm_mac_multichan.sv
// Bench for lpm_mac_multichan. Five configurations share one stimulus stream:
// the default SIGNED 16x16/P40 build, P=32 saturating, P=32 wrapping, UNSIGNED
// 8x8/P16, and a 3-channel build. A table covers the basic accumulate/dump
// and interleaving; short hand-written sequences cover overflow, stall/reset
// and bad channel ids.

module tb_lpm_mac_multichan;

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clock;
  logic        aclr_n;
  logic        clken;
  logic        in_valid;
  logic [1:0]  in_chan;
  logic        in_clear;
  logic        in_dump;
  logic [15:0] dataa;
  logic [15:0] datab;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT outputs ----------------
  logic a_ov, a_of, a_ce; logic [1:0] a_ch; logic [39:0] a_res;
  logic s_ov, s_of, s_ce; logic [1:0] s_ch; logic [31:0] s_res;
  logic w_ov, w_of, w_ce; logic [1:0] w_ch; logic [31:0] w_res;
  logic u_ov, u_of, u_ce; logic [1:0] u_ch; logic [15:0] u_res;
  logic c_ov, c_of, c_ce; logic [1:0] c_ch; logic [39:0] c_res;

  lpm_mac_multichan u_a (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_chan(in_chan),
    .in_clear(in_clear), .in_dump(in_dump), .dataa(dataa), .datab(datab),
    .out_valid(a_ov), .out_chan(a_ch), .result(a_res), .overflow(a_of), .chan_err(a_ce));

  lpm_mac_multichan #(.LPM_WIDTHP(32), .LPM_SATURATE(1'b1)) u_s (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_chan(in_chan),
    .in_clear(in_clear), .in_dump(in_dump), .dataa(dataa), .datab(datab),
    .out_valid(s_ov), .out_chan(s_ch), .result(s_res), .overflow(s_of), .chan_err(s_ce));

  lpm_mac_multichan #(.LPM_WIDTHP(32), .LPM_SATURATE(1'b0)) u_w (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_chan(in_chan),
    .in_clear(in_clear), .in_dump(in_dump), .dataa(dataa), .datab(datab),
    .out_valid(w_ov), .out_chan(w_ch), .result(w_res), .overflow(w_of), .chan_err(w_ce));

  lpm_mac_multichan #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16),
                      .LPM_REPRESENTATION("UNSIGNED")) u_u (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_chan(in_chan),
    .in_clear(in_clear), .in_dump(in_dump), .dataa(dataa[7:0]), .datab(datab[7:0]),
    .out_valid(u_ov), .out_chan(u_ch), .result(u_res), .overflow(u_of), .chan_err(u_ce));

  lpm_mac_multichan #(.LPM_CHANNELS(3)) u_c (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_chan(in_chan),
    .in_clear(in_clear), .in_dump(in_dump), .dataa(dataa), .datab(datab),
    .out_valid(c_ov), .out_chan(c_ch), .result(c_res), .overflow(c_of), .chan_err(c_ce));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic        clr;
    logic        dmp;
    logic [15:0] a;
    logic [15:0] b;
    logic        e_v;
    logic [1:0]  e_ch;
    logic [39:0] e_res;
    logic        e_of;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [1:0] ch, logic clr, logic dmp,
                              logic [15:0] a, logic [15:0] b,
                              logic e_v, logic [1:0] e_ch, logic [39:0] e_res, logic e_of);
    vec_t r;
    r.v = v; r.ch = ch; r.clr = clr; r.dmp = dmp; r.a = a; r.b = b;
    r.e_v = e_v; r.e_ch = e_ch; r.e_res = e_res; r.e_of = e_of;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] ch, logic clr, logic dmp,
                       logic [15:0] a, logic [15:0] b);
    in_valid = v;
    in_chan  = ch;
    in_clear = clr;
    in_dump  = dmp;
    dataa    = a;
    datab    = b;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Accumulate/dump on ch0: rows 0..6
    tbl[0] = mk(1, 2'd0, 1, 0, 16'd3,     16'd4, 0, 2'd0, 40'd0, 0);
    tbl[1] = mk(1, 2'd0, 0, 0, 16'hFFFE,  16'd5, 0, 2'd0, 40'd0, 0);
    tbl[2] = mk(1, 2'd0, 0, 1, 16'd7,     16'd1, 0, 2'd0, 40'd0, 0);
    tbl[3] = mk(0, 2'd0, 0, 0, 16'd0,     16'd0, 0, 2'd0, 40'd0, 0);
    tbl[4] = mk(0, 2'd0, 0, 0, 16'd0,     16'd0, 0, 2'd0, 40'd0, 0);
    tbl[5] = mk(0, 2'd0, 0, 0, 16'd0,     16'd0, 1, 2'd0, 40'd9, 0);
    // ch0 must be back at zero after the dump: adding 1*1 then dumping gives 1
    tbl[6] = mk(1, 2'd0, 0, 1, 16'd1,     16'd1, 0, 2'd0, 40'd9, 0);
    // Interleaved ch0..ch3, four rounds of (ch+1)*1, clear on first, dump on last
    for (int rd = 0; rd < 4; rd++) begin
      for (int c = 0; c < 4; c++) begin
        tbl[7 + rd*4 + c] = mk(1, 2'(c), (rd == 0), (rd == 3), 16'(c + 1), 16'd1,
                               0, 2'd0, 40'd1, 0);
      end
    end
    tbl[7].e_res = 40'd9;
    tbl[8].e_res = 40'd9;
    tbl[9].e_v   = 1'b1;
    tbl[22]      = mk(1, 2'd3, 0, 1, 16'd4, 16'd1, 1, 2'd0, 40'd4, 0);
    tbl[23]      = mk(0, 2'd0, 0, 0, 16'd0, 16'd0, 1, 2'd1, 40'd8, 0);
    tbl[24]      = mk(0, 2'd0, 0, 0, 16'd0, 16'd0, 1, 2'd2, 40'd12, 0);
    tbl[25]      = mk(0, 2'd0, 0, 0, 16'd0, 16'd0, 1, 2'd3, 40'd16, 0);
    tbl[26]      = mk(0, 2'd0, 0, 0, 16'd0, 16'd0, 0, 2'd3, 40'd16, 0);

    // ---- reset ----
    aclr_n = 1'b0;
    clken  = 1'b1;
    idle();
    step();
    step();
    check("reset out_valid", 64'(a_ov), 64'd0);
    check("reset out_chan",  64'(a_ch), 64'd0);
    check("reset result",    64'(a_res), 64'd0);
    check("reset overflow",  64'(a_of), 64'd0);
    check("reset chan_err",  64'(a_ce), 64'd0);
    aclr_n = 1'b1;
    step();

    // ---- table: basic accumulate and interleaving ----
    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].v, tbl[k].ch, tbl[k].clr, tbl[k].dmp, tbl[k].a, tbl[k].b);
      step();
      check($sformatf("row%0d out_valid", k), 64'(a_ov),  64'(tbl[k].e_v));
      check($sformatf("row%0d out_chan", k),  64'(a_ch),  64'(tbl[k].e_ch));
      check($sformatf("row%0d result", k),    64'(a_res), 64'(tbl[k].e_res));
      check($sformatf("row%0d overflow", k),  64'(a_of),  64'(tbl[k].e_of));
    end

    // ---- signed overflow: 3 x (-32768 * -32768) on ch1 ----
    drive(1, 2'd1, 1, 0, 16'h8000, 16'h8000); step();
    drive(1, 2'd1, 0, 0, 16'h8000, 16'h8000); step();
    drive(1, 2'd1, 0, 1, 16'h8000, 16'h8000); step();
    idle(); step();
    step();
    check("sat early out_valid", 64'(s_ov), 64'd0);
    step();
    check("sat out_valid",  64'(s_ov),  64'd1);
    check("sat out_chan",   64'(s_ch),  64'd1);
    check("sat result",     64'(s_res), 64'h7FFF_FFFF);
    check("sat overflow",   64'(s_of),  64'd1);
    check("wrap out_valid", 64'(w_ov),  64'd1);
    check("wrap result",    64'(w_res), 64'hC000_0000);
    check("wrap overflow",  64'(w_of),  64'd1);
    check("p40 result",     64'(a_res), 64'd3221225472);
    check("p40 overflow",   64'(a_of),  64'd0);

    // ---- unsigned overflow: 2 x (255*255), P=16 ----
    drive(1, 2'd2, 1, 0, 16'h00FF, 16'h00FF); step();
    drive(1, 2'd2, 0, 1, 16'h00FF, 16'h00FF); step();
    idle(); step();
    step();
    check("uns early out_valid", 64'(u_ov), 64'd0);
    step();
    check("uns out_valid", 64'(u_ov),  64'd1);
    check("uns out_chan",  64'(u_ch),  64'd2);
    check("uns result",    64'(u_res), 64'hFFFF);
    check("uns overflow",  64'(u_of),  64'd1);
    check("signed 255sq result", 64'(a_res), 64'd130050);

    // ---- clken stall with a dump in flight, then async reset ----
    drive(1, 2'd0, 1, 0, 16'd1, 16'd1); step();
    drive(1, 2'd1, 1, 1, 16'd2, 16'd2); step();
    clken = 1'b0;
    drive(1, 2'd3, 0, 1, 16'd5, 16'd5);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d out_valid", i), 64'(a_ov), 64'd0);
      check($sformatf("stall%0d result hold", i), 64'(a_res), 64'd130050);
    end
    aclr_n = 1'b0;
    #2;
    check("async reset out_valid", 64'(a_ov),  64'd0);
    check("async reset out_chan",  64'(a_ch),  64'd0);
    check("async reset result",    64'(a_res), 64'd0);
    check("async reset overflow",  64'(a_of),  64'd0);
    check("async reset chan_err",  64'(a_ce),  64'd0);
    clken = 1'b1;
    idle();
    step();
    aclr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post reset%0d out_valid", i), 64'(a_ov), 64'd0);
    end
    drive(1, 2'd0, 1, 1, 16'd2, 16'd3); step();
    idle(); step();
    step();
    check("post reset early out_valid", 64'(a_ov), 64'd0);
    step();
    check("post reset out_valid", 64'(a_ov),  64'd1);
    check("post reset out_chan",  64'(a_ch),  64'd0);
    check("post reset result",    64'(a_res), 64'd6);
    check("post reset overflow",  64'(a_of),  64'd0);

    // ---- bad channel id on the 3-channel build ----
    drive(1, 2'd0, 1, 0, 16'd5, 16'd1); step();
    drive(1, 2'd3, 1, 1, 16'd9, 16'd9); step();
    check("chan_err pulse",     64'(c_ce), 64'd1);
    check("chan_err 4ch quiet", 64'(a_ce), 64'd0);
    drive(1, 2'd0, 0, 1, 16'd0, 16'd0); step();
    check("chan_err end", 64'(c_ce), 64'd0);
    idle(); step();
    step();
    check("bad chan no out_valid", 64'(c_ov), 64'd0);
    step();
    check("3ch out_valid", 64'(c_ov),  64'd1);
    check("3ch out_chan",  64'(c_ch),  64'd0);
    check("3ch result",    64'(c_res), 64'd5);
    check("3ch overflow",  64'(c_of),  64'd0);
    step();
    check("3ch pulse end", 64'(c_ov), 64'd0);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
